// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_if
// Purpose  : Bundles the decode-side request, forwarding sources and the
//            registered EX-slot outputs of ex_operand_stage.
// Ports    : master -> drives decode/forwarding inputs and ex_ready,
//                      observes id_ready and the EX slot.
//            slave  -> the stage itself.
// Options  : HAZ_CNT_EN adds the 16-bit haz_cnt load-use stall counter.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_operand_stage_if #(
  parameter int REG_AW = 4,
  parameter int XLEN   = 32
);
  // Decode side
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [4:0]        opcode_in;
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic              use_imm;
  logic [REG_AW-1:0] rd_idx;
  logic              rd_we;
  logic              is_load;
  // Forwarding sources
  logic [XLEN-1:0]   alu_result;
  logic [REG_AW-1:0] mem_rd_idx;
  logic              mem_rd_we;
  logic [XLEN-1:0]   mem_result;
  // EX slot
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ALU_A_in;
  logic [XLEN-1:0]   ALU_B_in;
  logic [4:0]        opcode;
  logic [REG_AW-1:0] ex_rd_idx;
  logic              ex_rd_we;
  logic              ex_is_load;
`ifdef HAZ_CNT_EN
  logic [15:0]       haz_cnt;

  modport master (
    output flush, id_valid, opcode_in, rs1_idx, rs2_idx, rs1_data, rs2_data,
           imm, use_imm, rd_idx, rd_we, is_load, alu_result, mem_rd_idx,
           mem_rd_we, mem_result, ex_ready,
    input  id_ready, ex_valid, ALU_A_in, ALU_B_in, opcode, ex_rd_idx,
           ex_rd_we, ex_is_load, haz_cnt
  );

  modport slave (
    input  flush, id_valid, opcode_in, rs1_idx, rs2_idx, rs1_data, rs2_data,
           imm, use_imm, rd_idx, rd_we, is_load, alu_result, mem_rd_idx,
           mem_rd_we, mem_result, ex_ready,
    output id_ready, ex_valid, ALU_A_in, ALU_B_in, opcode, ex_rd_idx,
           ex_rd_we, ex_is_load, haz_cnt
  );
`else
  modport master (
    output flush, id_valid, opcode_in, rs1_idx, rs2_idx, rs1_data, rs2_data,
           imm, use_imm, rd_idx, rd_we, is_load, alu_result, mem_rd_idx,
           mem_rd_we, mem_result, ex_ready,
    input  id_ready, ex_valid, ALU_A_in, ALU_B_in, opcode, ex_rd_idx,
           ex_rd_we, ex_is_load
  );

  modport slave (
    input  flush, id_valid, opcode_in, rs1_idx, rs2_idx, rs1_data, rs2_data,
           imm, use_imm, rd_idx, rd_we, is_load, alu_result, mem_rd_idx,
           mem_rd_we, mem_result, ex_ready,
    output id_ready, ex_valid, ALU_A_in, ALU_B_in, opcode, ex_rd_idx,
           ex_rd_we, ex_is_load
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register in front of the ALU. Resolves operands
//            with EX/MEM forwarding, stalls on load-use hazards and inserts
//            a bubble while the load moves on to MEM.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - ex_operand_stage_if.slave (decode request, forwarding
//                    sources, ex_ready in; id_ready and EX slot out)
// Options  : HAZ_CNT_EN - adds bus.haz_cnt, a saturating 16-bit count of
//            cycles in which a valid decode was held by a load-use hazard.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
  parameter int REG_AW = 4,
  parameter int XLEN   = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ex_operand_stage_if.slave  bus
);

  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

  // EX slot registers
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_alu_a;
  logic [XLEN-1:0]   r_alu_b;
  logic [4:0]        r_opcode;
  logic [REG_AW-1:0] r_rd_idx;
  logic              r_rd_we;
  logic              r_is_load;

  logic              w_src2_used;
  logic              w_hazard;
  logic              w_id_ready;
  logic              w_accept;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic [XLEN-1:0]   w_op_b;

  // Only a non-load in the EX slot has its result ready on alu_result;
  // a load there is covered by the hazard stall and picked up from MEM.
  function automatic logic [XLEN-1:0] f_forward(
    input logic [REG_AW-1:0] idx,
    input logic [XLEN-1:0]   rf_data
  );
    logic [XLEN-1:0] v;
    if (idx == c_REG_ZERO)
      v = '0;
    else if (r_ex_valid && r_rd_we && !r_is_load && (r_rd_idx == idx))
      v = bus.alu_result;
    else if (bus.mem_rd_we && (bus.mem_rd_idx == idx))
      v = bus.mem_result;
    else
      v = rf_data;
    return v;
  endfunction

  assign w_src2_used = !bus.use_imm;

  // Opcode is deliberately ignored: rs2 is compared whenever use_imm is low.
  assign w_hazard = r_ex_valid && r_is_load && r_rd_we &&
                    (r_rd_idx != c_REG_ZERO) &&
                    ((bus.rs1_idx == r_rd_idx) ||
                     (w_src2_used && (bus.rs2_idx == r_rd_idx)));

  // A flush empties the slot this edge, so decode may always present.
  assign w_id_ready = bus.flush || (!w_hazard && (!r_ex_valid || bus.ex_ready));
  assign w_accept   = bus.id_valid && w_id_ready;

  assign w_fwd_rs1  = f_forward(bus.rs1_idx, bus.rs1_data);
  assign w_fwd_rs2  = f_forward(bus.rs2_idx, bus.rs2_data);
  assign w_op_b     = bus.use_imm ? bus.imm : w_fwd_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_opcode   <= '0;
      r_rd_idx   <= '0;
      r_rd_we    <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_alu_a    <= w_fwd_rs1;
      r_alu_b    <= w_op_b;
      r_opcode   <= bus.opcode_in;
      r_rd_idx   <= bus.rd_idx;
      r_rd_we    <= bus.rd_we;
      r_is_load  <= bus.is_load;
    end else if (w_hazard && bus.ex_ready) begin
      // Load leaves for MEM; the stalled consumer enters next cycle.
      r_ex_valid <= 1'b0;
    end else if (r_ex_valid && bus.ex_ready && !bus.id_valid) begin
      r_ex_valid <= 1'b0;
    end
  end

`ifdef HAZ_CNT_EN
  logic [15:0] r_haz_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_haz_cnt <= '0;
    else if (bus.id_valid && w_hazard && !bus.flush && (r_haz_cnt != 16'hFFFF))
      r_haz_cnt <= r_haz_cnt + 16'd1;
  end

  assign bus.haz_cnt = r_haz_cnt;
`endif

  assign bus.id_ready   = w_id_ready;
  assign bus.ex_valid   = r_ex_valid;
  assign bus.ALU_A_in   = r_alu_a;
  assign bus.ALU_B_in   = r_alu_b;
  assign bus.opcode     = r_opcode;
  assign bus.ex_rd_idx  = r_rd_idx;
  assign bus.ex_rd_we   = r_rd_we;
  assign bus.ex_is_load = r_is_load;

endmodule
`default_nettype wire
